// File: rtl/alu_cmd_ctrl.sv
// Packet command controller between a UART byte stream and an unsigned ALU (ECHO/ADD/MUL/DIV).
// Latency: echo bytes appear on tx one cycle after rx; the result goes out four bytes LSB first after the last ALU result.
// Backpressure: rx has none (a full hold register or a busy TX drops the byte and sets err_o); tx and ALU use valid/ready.
module alu_cmd_ctrl #(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 28000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_result_valid_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAYLOAD, S_ALU_REQ, S_ALU_WAIT, S_TX_RESULT, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   byte_cnt_q, byte_cnt_d, cnt_inc;
  logic [7:0]    op_q, len_lo_q, hold_dat_q;
  logic [15:0]   len_q;
  logic          len_ok_q, err_q, set_err;
  logic [31:0]   acc_q, opnd_q, b_q, opnd_val;
  logic          last_q, alu_pend_q, hold_vld_q, hold_vld_d, to_flag_q;
  logic [1:0]    tx_idx_q;
  logic [TW-1:0] to_cnt_q;

  logic        is_echo, is_arith, tx_fire, alu_fire, res_ok, timed, to_hit;
  logic        hdr_end, hdr_bad, echo_take, echo_drop, arith_byte, opnd_done, first_opnd;
  logic        req_new, abort, stray, drain_done;
  logic [15:0] hdr_len;
  logic [7:0]  acc_byte;

  // Shared event decode used by both the FSM and the datapath.
  always_comb begin
    is_echo    = (op_q == 8'hEC);
    is_arith   = (op_q == 8'hAD) || (op_q == 8'h88) || (op_q == 8'h86);
    tx_fire    = tx_valid_o && tx_ready_i;
    alu_fire   = alu_valid_o && alu_ready_i;
    res_ok     = alu_result_valid_i && alu_pend_q;
    cnt_inc    = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
    byte_cnt_d = !rx_valid_i ? byte_cnt_q : (state_q == S_IDLE) ? 16'd1 : cnt_inc;
    timed      = (state_q == S_HDR) || (state_q == S_PAYLOAD) || (state_q == S_DRAIN);
    to_hit     = timed && !rx_valid_i && (to_cnt_q == TO_LAST);
    hdr_len    = {rx_data_i, len_lo_q};
    hdr_end    = (state_q == S_HDR) && rx_valid_i && (byte_cnt_q == 16'd3);
    hdr_bad    = !(is_arith || is_echo) || (hdr_len < 16'd4) || (hdr_len > 16'(MAX_LEN)) ||
                 (is_arith && ((hdr_len[1:0] != 2'b00) || (hdr_len < 16'd12)));
    // A hold slot being emptied this cycle can take the new byte.
    echo_take  = (state_q == S_PAYLOAD) && is_echo && rx_valid_i && (byte_cnt_q < len_q) &&
                 (!hold_vld_q || tx_ready_i);
    echo_drop  = (state_q == S_PAYLOAD) && is_echo && rx_valid_i && !echo_take;
    hold_vld_d = echo_take || (hold_vld_q && !tx_ready_i);
    arith_byte = rx_valid_i && !is_echo && !last_q &&
                 ((state_q == S_PAYLOAD) || (state_q == S_ALU_REQ) || (state_q == S_ALU_WAIT));
    opnd_val   = {rx_data_i, opnd_q[31:8]};
    opnd_done  = arith_byte && (byte_cnt_q[1:0] == 2'b11);
    first_opnd = (byte_cnt_q < 16'd8);
    req_new    = opnd_done && !first_opnd &&
                 ((state_q == S_PAYLOAD) || ((state_q == S_ALU_WAIT) && res_ok));
    abort      = opnd_done && !first_opnd &&
                 ((state_q == S_ALU_REQ) || ((state_q == S_ALU_WAIT) && !res_ok));
    stray      = rx_valid_i && last_q && ((state_q == S_ALU_REQ) || (state_q == S_ALU_WAIT));
    drain_done = !len_ok_q || (byte_cnt_d >= len_q) || to_flag_q || to_hit;
    case (tx_idx_q)
      2'd0:    acc_byte = acc_q[7:0];
      2'd1:    acc_byte = acc_q[15:8];
      2'd2:    acc_byte = acc_q[23:16];
      default: acc_byte = acc_q[31:24];
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and error detection.
  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: if (rx_valid_i) state_d = S_HDR;
      S_HDR: begin
        if (to_hit) begin
          state_d = S_IDLE;
          set_err = 1'b1;
        end else if (hdr_end) begin
          if (hdr_bad) begin
            state_d = S_DRAIN;
            set_err = 1'b1;
          end else if (hdr_len == 16'd4) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (to_hit) begin
          state_d = S_IDLE;
          set_err = 1'b1;
        end else if (is_echo) begin
          if (echo_drop) set_err = 1'b1;
          if ((byte_cnt_d >= len_q) && !hold_vld_d) state_d = S_IDLE;
        end else if (req_new) begin
          state_d = S_ALU_REQ;
        end
      end
      S_ALU_REQ: begin
        if (stray) set_err = 1'b1;
        if (abort) begin
          state_d = S_DRAIN;
          set_err = 1'b1;
        end else if (alu_fire) begin
          state_d = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (stray) set_err = 1'b1;
        if (abort) begin
          state_d = S_DRAIN;
          set_err = 1'b1;
        end else if (res_ok) begin
          if (req_new)     state_d = S_ALU_REQ;
          else if (last_q) state_d = S_TX_RESULT;
          else             state_d = S_PAYLOAD;
        end
      end
      S_TX_RESULT: begin
        if (rx_valid_i) set_err = 1'b1;
        if (tx_fire && !hold_vld_q && (tx_idx_q == 2'd3)) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (to_hit) set_err = 1'b1;
        if (drain_done && !(alu_pend_q && !alu_result_valid_i)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Packet datapath: counters, header fields, operands, accumulator, hold register, timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      op_q       <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      len_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      opnd_q     <= '0;
      b_q        <= '0;
      last_q     <= 1'b0;
      alu_pend_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      tx_idx_q   <= '0;
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      if ((state_q == S_IDLE) && rx_valid_i) begin
        op_q     <= rx_data_i;
        len_ok_q <= 1'b0;
        last_q   <= 1'b0;
      end
      if ((state_q == S_HDR) && rx_valid_i && (byte_cnt_q == 16'd2)) len_lo_q <= rx_data_i;
      if (hdr_end) begin
        len_q    <= hdr_len;
        len_ok_q <= (hdr_len >= 16'd4);
      end
      if ((state_q == S_IDLE) && rx_valid_i) err_q <= 1'b0;
      else if (set_err)                      err_q <= 1'b1;
      if (arith_byte) opnd_q <= opnd_val;
      if ((state_q == S_PAYLOAD) && opnd_done && first_opnd) acc_q <= opnd_val;
      else if ((state_q == S_ALU_WAIT) && res_ok)          acc_q <= alu_result_i;
      if (req_new) begin
        b_q    <= opnd_val;
        last_q <= (cnt_inc == len_q);
      end
      alu_pend_q <= (alu_pend_q && !alu_result_valid_i) || alu_fire;
      hold_vld_q <= hold_vld_d;
      if (echo_take) hold_dat_q <= rx_data_i;
      if (state_q != S_TX_RESULT)        tx_idx_q <= '0;
      else if (tx_fire && !hold_vld_q)   tx_idx_q <= tx_idx_q + 2'd1;
      if (rx_valid_i || !timed)          to_cnt_q <= '0;
      else if (to_cnt_q != TO_LAST)      to_cnt_q <= to_cnt_q + 1'b1;
      if (state_q == S_IDLE)                   to_flag_q <= 1'b0;
      else if ((state_q == S_DRAIN) && to_hit) to_flag_q <= 1'b1;
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    err_o       = err_q;
    alu_valid_o = (state_q == S_ALU_REQ);
    alu_a_o     = acc_q;
    alu_b_o     = b_q;
    case (op_q)
      8'h88:   alu_op_o = 2'd1;
      8'h86:   alu_op_o = 2'd2;
      default: alu_op_o = 2'd0;
    endcase
    tx_valid_o  = hold_vld_q || (state_q == S_TX_RESULT);
    tx_data_o   = hold_vld_q ? hold_dat_q : acc_byte;
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed-vector bench for alu_cmd_ctrl: echo, arithmetic chains, header errors, overrun, timeout, abort, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// TX and ALU handshakes are recorded by monitors on the rising edge.
module tb_alu_cmd_ctrl;
  localparam int TO = 28000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_valid_o, alu_ready_i;
  logic [31:0] alu_result_i;
  logic        alu_result_valid_i;
  logic        busy_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tx_q[$];
  int          alu_req_n = 0;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;

  always #5 clk_i = ~clk_i;

  alu_cmd_ctrl #(.MAX_LEN(64), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_result_i(alu_result_i), .alu_result_valid_i(alu_result_valid_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always @(posedge clk_i) begin
    if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    if (alu_valid_o && alu_ready_i) begin
      alu_req_n = alu_req_n + 1;
      req_op    = alu_op_o;
      req_a     = alu_a_o;
      req_b     = alu_b_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick(1);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send(op); send(8'h00); send(len[7:0]); send(len[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic strobe(input logic [31:0] r);
    alu_result_i       = r;
    alu_result_valid_i = 1'b1;
    tick(1);
    alu_result_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int k = 0; k < max_cyc && busy_o; k++) tick(1);
  endtask

  function automatic logic [31:0] tx_word();
    logic [31:0] w = '0;
    for (int i = 0; i < tx_q.size() && i < 4; i++) w[8*i +: 8] = tx_q[i];
    return w;
  endfunction

  initial begin
    rst_ni = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
    alu_ready_i = 1'b1; alu_result_i = '0; alu_result_valid_i = 1'b0;
    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_alu_valid", alu_valid_o, 0);
    rst_ni = 1'b1;
    tick(1);

    // ADD 5 + 7 -> 12
    send_hdr(8'hAD, 16'd12); send_word(32'd5); send_word(32'd7);
    tick(2);
    check("add_req_n", alu_req_n, 1);
    check("add_op", req_op, 0);
    check("add_a", req_a, 32'd5);
    check("add_b", req_b, 32'd7);
    check("add_busy_wait", busy_o, 1);
    strobe(32'd12);
    wait_idle(20);
    check("add_idle", busy_o, 0);
    check("add_tx_n", tx_q.size(), 4);
    check("add_tx", tx_word(), 32'h0000000C);
    check("add_err", err_o, 0);
    tx_q.delete();

    // MUL chain 3 * 4 * 5, result fed back as the next a
    send_hdr(8'h88, 16'd16); send_word(32'd3); send_word(32'd4);
    tick(2);
    check("mul1_a", req_a, 32'd3);
    check("mul1_b", req_b, 32'd4);
    strobe(32'd12);
    send_word(32'd5);
    tick(2);
    check("mul_req_n", alu_req_n, 3);
    check("mul2_op", req_op, 1);
    check("mul2_a", req_a, 32'd12);
    check("mul2_b", req_b, 32'd5);
    strobe(32'd60);
    wait_idle(20);
    check("mul_tx_n", tx_q.size(), 4);
    check("mul_tx", tx_word(), 32'd60);
    tx_q.delete();

    // ECHO three bytes
    send_hdr(8'hEC, 16'd7); send(8'h41); send(8'h42); send(8'h43);
    wait_idle(20);
    check("echo_idle", busy_o, 0);
    check("echo_tx_n", tx_q.size(), 3);
    check("echo_tx", tx_word(), 32'h00434241);
    check("echo_err", err_o, 0);
    tx_q.delete();

    // Bad opcode: drained to len 8 with no output
    send_hdr(8'h55, 16'd8); send(8'h01); send(8'h02); send(8'h03);
    check("bad_busy_before_last", busy_o, 1);
    check("bad_err", err_o, 1);
    send(8'h04);
    check("bad_idle_after_8", busy_o, 0);
    check("bad_tx_n", tx_q.size(), 0);
    send(8'hEC);
    check("new_pkt_clears_err", err_o, 0);
    send(8'h00); send(8'h04); send(8'h00);
    check("echo_len4_idle", busy_o, 0);
    check("echo_len4_tx_n", tx_q.size(), 0);

    // Echo overrun under backpressure
    tx_ready_i = 1'b0;
    send_hdr(8'hEC, 16'd6); send(8'h61); send(8'h62);
    check("ovr_err", err_o, 1);
    check("ovr_tx_valid", tx_valid_o, 1);
    check("ovr_tx_data", tx_data_o, 8'h61);
    check("ovr_busy", busy_o, 1);
    tx_ready_i = 1'b1;
    wait_idle(20);
    check("ovr_idle", busy_o, 0);
    check("ovr_tx_n", tx_q.size(), 1);
    check("ovr_tx", tx_word(), 32'h61);
    tx_q.delete();

    // Timeout boundary after header
    send_hdr(8'hAD, 16'd12);
    tick(TO - 1);
    check("to_busy_before", busy_o, 1);
    check("to_err_before", err_o, 0);
    tick(1);
    check("to_busy_after", busy_o, 0);
    check("to_err_after", err_o, 1);

    // DIV: next operand completes before the result returns -> abort
    send_hdr(8'h86, 16'd16); send_word(32'd100); send_word(32'd5); send_word(32'd7);
    check("div_op", req_op, 2);
    check("div_a", req_a, 32'd100);
    check("div_b", req_b, 32'd5);
    check("abort_err", err_o, 1);
    check("abort_busy_pending", busy_o, 1);
    strobe(32'd20);
    check("abort_idle", busy_o, 0);
    check("abort_tx_n", tx_q.size(), 0);

    // Reset while waiting for the ALU
    send_hdr(8'hAD, 16'd12); send_word(32'd9); send_word(32'd1);
    tick(2);
    check("rw_busy", busy_o, 1);
    check("rw_err_cleared", err_o, 0);
    #2 rst_ni = 1'b0;
    #1;
    check("rw_busy_rst", busy_o, 0);
    check("rw_alu_valid_rst", alu_valid_o, 0);
    check("rw_tx_valid_rst", tx_valid_o, 0);
    check("rw_alu_a_rst", alu_a_o, 0);
    tick(1);
    rst_ni = 1'b1;
    tick(1);
    strobe(32'd10);
    tick(10);
    check("rw_late_tx_n", tx_q.size(), 0);
    check("rw_late_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter MAX_LEN, 64: maximum accepted packet length in bytes, header included.
REQ-002 Parameter TIMEOUT_CYC, 28000: idle cycles tolerated between bytes of one packet.
REQ-003 Port clk_i input 1: single clock; all logic rising-edge.
REQ-004 Port rst_ni input 1: reset, asynchronous, active-low.
REQ-005 Port rx_data_i input 8: received byte from UART RX.
REQ-006 Port rx_valid_i input 1: one-cycle strobe qualifying rx_data_i; no backpressure.
REQ-007 Port tx_data_o output 8: byte to UART TX.
REQ-008 Port tx_valid_o output 1: tx_data_o valid; transfer on tx_valid_o && tx_ready_i.
REQ-009 Port tx_ready_i input 1: UART TX can accept a byte.
REQ-010 Port alu_op_o output 2: 0 ADD, 1 MUL, 2 DIV (unsigned); 3 unused.
REQ-011 Ports alu_a_o, alu_b_o output 32 each: ALU operands.
REQ-012 Port alu_valid_o output 1 / alu_ready_i input 1: ALU request handshake; accepted when both high.
REQ-013 Ports alu_result_i input 32, alu_result_valid_i input 1: ALU result, one-cycle strobe.
REQ-014 Port busy_o output 1: high in every state except IDLE.
REQ-015 Port err_o output 1: sticky error flag.

Function
REQ-016 Packet: byte0 opcode, byte1 ignored, byte2/byte3 length LSB first (total bytes incl. 4-byte header), then payload; multi-byte values little-endian.
REQ-017 Opcodes: 0xEC ECHO, 0xAD ADD, 0x88 MUL, 0x86 DIV.
REQ-018 States: IDLE, HDR, PAYLOAD, ALU_REQ, ALU_WAIT, TX_RESULT, DRAIN.
REQ-019 IDLE: first rx byte -> HDR, clears err_o, byte counter = 1.
REQ-020 After byte3, header check: unknown opcode, len<4, len>MAX_LEN, or arithmetic with (len-4) not multiple of 4 or <8 -> err_o=1, DRAIN.
REQ-021 Valid header with len==4: ECHO -> IDLE, no output; arithmetic rejected per REQ-020.
REQ-022 ECHO: each payload byte loaded into 1-entry hold register, presented on tx_data_o next cycle; hold cleared on transfer.
REQ-023 ECHO overrun: rx byte arrives while hold full -> byte dropped, err_o=1, packet continues counting.
REQ-024 Arithmetic: first 32-bit operand -> accumulator; each later operand assembled in a separate 32-bit register, then ALU_REQ with a=acc, b=operand.
REQ-025 ALU_REQ: alu_valid_o, op, a, b held stable until accepted; then ALU_WAIT; on alu_result_valid_i acc <= alu_result_i.
REQ-026 Operand bytes keep assembling during ALU_REQ/ALU_WAIT; next operand completing before result returns -> err_o=1, DRAIN (abort).
REQ-027 After last operand's result: TX_RESULT sends acc as 4 bytes LSB first, one per handshake, then IDLE.
REQ-028 rx byte during TX_RESULT: dropped, err_o=1; transmission completes.
REQ-029 DRAIN: discards rx bytes until byte count reaches len (or immediately IDLE if len unknown/<4), no tx; waits for pending ALU result (ignored) before IDLE.
REQ-030 Timeout: counter resets on each rx byte; in HDR/PAYLOAD/DRAIN reaching TIMEOUT_CYC -> err_o=1, IDLE (after pending ALU result, if any).
REQ-031 Byte counter 16 bits, saturating; no wrap.
REQ-032 rx_valid_i same cycle as tx transfer or ALU result: all events processed that cycle, none lost.

Reset
REQ-033 rst_ni low asynchronously forces IDLE; tx_valid_o, alu_valid_o, busy_o, err_o = 0; acc, operand, counters, hold register = 0; in-flight packet discarded, late alu_result_valid_i after reset ignored.

Verification
REQ-034 ADD: EC-free packet AD 00 0C 00, 05000000, 07000000 -> ALU req op=0 a=5 b=7; result 12 -> tx 0C 00 00 00; err_o=0.
REQ-035 ECHO: EC 00 07 00 41 42 43, tx_ready_i=1 -> tx 41 42 43, IDLE, err_o=0.
REQ-036 Bad opcode 55 00 08 00 + 4 bytes -> err_o=1, no tx, IDLE after 8th byte; next valid packet clears err_o.
REQ-037 Timeout: AD 00 0C 00 then silence TIMEOUT_CYC cycles -> err_o=1, IDLE, busy_o=0.
REQ-038 Backpressure/overrun: ECHO with tx_ready_i=0 for two byte times -> first byte held, second dropped, err_o=1.
REQ-039 Reset mid-ALU_WAIT: rst_ni low -> all outputs 0 immediately; subsequent result strobe causes no tx.
